// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//
// Shares one single-port program RAM between the CPU instruction-fetch port
// and a host loader/debug port. Every RAM access is sequenced by one FSM
// (IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE), so host writes and CPU fetches
// are fully serialized.
//
// Build option:
//   IMEM_ARB_RR_EN  defined   : round-robin grant when both ports request
//                   undefined : fixed priority, host over CPU (default)
//
// Parameters:
//   AW      address width of both ports and of the RAM
//   DW      data / instruction width
//   RD_LAT  RAM read latency in cycles, 1..15 (ram_en edge to valid ram_rdata)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   cpu_req      fetch request (level)
//   cpu_addr     fetch address
//   cpu_ins      fetched instruction, held until the next fetch completes
//   cpu_vld      one-cycle pulse when cpu_ins is updated
//   host_req     host access request (level)
//   host_we      1 = write, 0 = read
//   host_addr    host address
//   host_wdata   host write data
//   host_rdata   host read data, held until the next host read completes
//   host_ack     one-cycle completion pulse
//   ram_en       RAM access strobe
//   ram_we       RAM write enable
//   ram_addr     RAM address
//   ram_wdata    RAM write data
//   ram_rdata    RAM read data
// ---------------------------------------------------------------------------
module imem_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_ins,
  output logic          cpu_vld,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ack,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // The counter is 4 bits wide, which bounds RD_LAT to 1..15.
  localparam logic [3:0] LAT_INIT = 4'(RD_LAT);

  state_e        state_q;
  logic          owner_host_q;   // 1: host owns the current transaction
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    cnt_q;

  logic [DW-1:0] cpu_ins_q;
  logic [DW-1:0] host_rdata_q;
  logic          cpu_vld_q;
  logic          host_ack_q;
  logic          ram_en_q;
  logic          ram_we_q;

  logic          grant_host_d;

`ifdef IMEM_ARB_RR_EN
  logic          last_host_q;    // 1: host completed the most recent access

  // On contention, grant the port that did not finish last.
  always_comb begin
    grant_host_d = host_req && (!cpu_req || !last_host_q);
  end
`else
  always_comb begin
    grant_host_d = host_req;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_host_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cpu_ins_q    <= '0;
      host_rdata_q <= '0;
      cpu_vld_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
`ifdef IMEM_ARB_RR_EN
      last_host_q  <= 1'b0;
`endif
    end else begin
      // Strobes and pulses are single-cycle unless a state sets them below.
      cpu_vld_q  <= 1'b0;
      host_ack_q <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cpu_req || host_req) begin
            // Freeze the whole grant; requester changes are ignored
            // until the FSM is back in IDLE.
            owner_host_q <= grant_host_d;
            we_q         <= grant_host_d && host_we;
            addr_q       <= grant_host_d ? host_addr : cpu_addr;
            wdata_q      <= grant_host_d ? host_wdata : '0;
            // RAM strobes are registered so they line up with ACCESS.
            ram_en_q     <= 1'b1;
            ram_we_q     <= grant_host_d && host_we;
            state_q      <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          if (we_q) begin
            // Only the host can write; the write completes on this edge.
            host_ack_q <= owner_host_q;
            cpu_vld_q  <= !owner_host_q;
            state_q    <= S_RESP;
          end else begin
            cnt_q   <= LAT_INIT;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            // ram_rdata is valid on this edge; capture for the owner only.
            if (owner_host_q) begin
              host_rdata_q <= ram_rdata;
              host_ack_q   <= 1'b1;
            end else begin
              cpu_ins_q    <= ram_rdata;
              cpu_vld_q    <= 1'b1;
            end
            cnt_q   <= '0;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_RESP: begin
`ifdef IMEM_ARB_RR_EN
          last_host_q <= owner_host_q;
`endif
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_ins    = cpu_ins_q;
  assign cpu_vld    = cpu_vld_q;
  assign host_rdata = host_rdata_q;
  assign host_ack   = host_ack_q;
  assign ram_en     = ram_en_q;
  assign ram_we     = ram_we_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = wdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter
//
// Two arbiter instances: index 0 with RD_LAT=1, index 1 with RD_LAT=4, each
// attached to a behavioural RAM with the matching read latency. Directed
// stimulus pushes the expected pulse (port, cycle, data) into a scoreboard;
// a monitor on the falling edge pops and compares whenever cpu_vld/host_ack
// is seen. Cycle numbers are the count of rising edges seen so far; a request
// driven on the falling edge of cycle n is sampled by IDLE on edge n+1, so a
// response with latency L is observed on the falling edge of cycle n+L.
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req    [2];
  logic [15:0] cpu_addr   [2];
  logic [15:0] cpu_ins    [2];
  logic        cpu_vld    [2];
  logic        host_req   [2];
  logic        host_we    [2];
  logic [15:0] host_addr  [2];
  logic [15:0] host_wdata [2];
  logic [15:0] host_rdata [2];
  logic        host_ack   [2];
  logic        ram_en     [2];
  logic        ram_we     [2];
  logic [15:0] ram_addr   [2];
  logic [15:0] ram_wdata  [2];
  logic [15:0] ram_rdata  [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 4;
    logic [15:0] mem  [0:65535];
    logic [15:0] pipe [0:LAT-1];

    imem_arbiter #(.AW(16), .DW(16), .RD_LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req[gi]),
      .cpu_addr   (cpu_addr[gi]),
      .cpu_ins    (cpu_ins[gi]),
      .cpu_vld    (cpu_vld[gi]),
      .host_req   (host_req[gi]),
      .host_we    (host_we[gi]),
      .host_addr  (host_addr[gi]),
      .host_wdata (host_wdata[gi]),
      .host_rdata (host_rdata[gi]),
      .host_ack   (host_ack[gi]),
      .ram_en     (ram_en[gi]),
      .ram_we     (ram_we[gi]),
      .ram_addr   (ram_addr[gi]),
      .ram_wdata  (ram_wdata[gi]),
      .ram_rdata  (ram_rdata[gi])
    );

    // Read data appears LAT edges after the ram_en edge.
    always @(posedge clk) begin
      if (ram_en[gi] && ram_we[gi]) mem[ram_addr[gi]] <= ram_wdata[gi];
      if (ram_en[gi] && !ram_we[gi]) pipe[0] <= mem[ram_addr[gi]];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata[gi] = pipe[LAT-1];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          u;     // instance
    int          k;     // 0 = cpu_vld, 1 = host_ack
    int          cyc;   // expected observation cycle
    logic [15:0] data;
    bit          chk;   // compare data
  } exp_t;

  exp_t sb[$];

  task automatic expect_pulse(input int u, input int k, input int c,
                              input logic [15:0] d, input bit chk);
    exp_t e;
    e.u = u; e.k = k; e.cyc = c; e.data = d; e.chk = chk;
    sb.push_back(e);
  endtask

  logic prev_en [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    logic        p;
    logic [15:0] act;
    int          idx;
    exp_t        e;
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 2; k++) begin
        p   = (k == 1) ? host_ack[u] : cpu_vld[u];
        act = (k == 1) ? host_rdata[u] : cpu_ins[u];
        if (p) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].u == u && sb[i].k == k) begin
              idx = i;
              break;
            end
          end
          n_cmp++;
          if (idx < 0) begin
            n_bad++;
            $display("FAIL unexpected_%s inst%0d: pulse at cyc %0d, required none",
                     (k == 1) ? "host_ack" : "cpu_vld", u, cyc);
          end else begin
            e = sb[idx];
            sb.delete(idx);
            if (e.cyc != cyc || (e.chk && act !== e.data)) begin
              n_bad++;
              $display("FAIL %s inst%0d: got cyc=%0d data=%h, required cyc=%0d data=%h",
                       (k == 1) ? "host_ack" : "cpu_vld", u, cyc, act, e.cyc,
                       e.chk ? e.data : act);
            end else begin
              $display("inst%0d %s cyc=%0d data=%h ok",
                       u, (k == 1) ? "host_ack" : "cpu_vld", cyc, act);
            end
          end
        end
      end
      if (cpu_vld[u] || host_ack[u]) begin
        n_cmp++;
        if (cpu_vld[u] && host_ack[u]) begin
          n_bad++;
          $display("FAIL both_pulses inst%0d: cpu_vld=1 host_ack=1 at cyc %0d, required one", u, cyc);
        end
      end
      if (ram_en[u]) begin
        n_cmp++;
        if (prev_en[u]) begin
          n_bad++;
          $display("FAIL ram_en_twice inst%0d: ram_en high two cycles at cyc %0d, required one", u, cyc);
        end
      end
      if (ram_we[u]) begin
        n_cmp++;
        if (!ram_en[u]) begin
          n_bad++;
          $display("FAIL ram_we_outside_access inst%0d: ram_we=1 ram_en=0 at cyc %0d", u, cyc);
        end
      end
      prev_en[u] = ram_en[u];
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_pulse(input int u, input int k, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (k == 1) ? host_ack[u] : cpu_vld[u];
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s inst%0d: no pulse in %0d cycles, required one",
               (k == 1) ? "host_ack" : "cpu_vld", u, budget);
    end
  endtask

  task automatic host_txn(input int u, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int lat,
                          input logic [15:0] exp_rdata);
    @(negedge clk);
    expect_pulse(u, 1, cyc + lat, exp_rdata, !we);
    host_we[u]    = we;
    host_addr[u]  = addr;
    host_wdata[u] = wdata;
    host_req[u]   = 1'b1;
    wait_pulse(u, 1, 40);
    host_req[u] = 1'b0;
  endtask

  task automatic cpu_txn(input int u, input logic [15:0] addr, input int lat,
                         input logic [15:0] exp_ins);
    @(negedge clk);
    expect_pulse(u, 0, cyc + lat, exp_ins, 1'b1);
    cpu_addr[u] = addr;
    cpu_req[u]  = 1'b1;
    wait_pulse(u, 0, 40);
    cpu_req[u] = 1'b0;
  endtask

  task automatic check_zero(input int u, input string tag);
    logic [69:0] all_out;
    all_out = {cpu_ins[u], cpu_vld[u], host_rdata[u], host_ack[u],
               ram_en[u], ram_we[u], ram_addr[u], ram_wdata[u]};
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++;
      $display("FAIL %s inst%0d: outputs=%h, required all zero", tag, u, all_out);
    end else begin
      $display("inst%0d %s outputs zero ok", u, tag);
    end
  endtask

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", tag, act, req);
    end else begin
      $display("%s = %h ok", tag, act);
    end
  endtask

  // ---------------- stimulus ----------------
  int base;
  int n_cpu_burst;
  int vld_seen;

  initial begin
    for (int u = 0; u < 2; u++) begin
      cpu_req[u] = 1'b0; cpu_addr[u] = '0;
      host_req[u] = 1'b0; host_we[u] = 1'b0;
      host_addr[u] = '0; host_wdata[u] = '0;
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    check_zero(0, "reset_initial");
    check_zero(1, "reset_initial");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Host loads the program, then reads a word back.
    host_txn(0, 1'b1, 16'h0000, 16'h0008, 2, 16'h0000);
    host_txn(0, 1'b1, 16'h0001, 16'h0402, 2, 16'h0000);
    host_txn(0, 1'b0, 16'h0001, 16'h0000, 3, 16'h0402);

    // CPU fetch; the instruction must hold after cpu_req drops.
    cpu_txn(0, 16'h0000, 3, 16'h0008);
    repeat (3) @(negedge clk);
    check_val("cpu_ins_hold", cpu_ins[0], 16'h0008);

    // Old contents of addr 6; also leaves the host as last owner.
    host_txn(0, 1'b1, 16'h0006, 16'h1111, 2, 16'h0000);

    // Simultaneous host write and CPU fetch of the same address.
    @(negedge clk);
    base = cyc;
`ifdef IMEM_ARB_RR_EN
    expect_pulse(0, 0, base + 3, 16'h1111, 1'b1);
    expect_pulse(0, 1, base + 6, 16'h0000, 1'b0);
`else
    expect_pulse(0, 1, base + 2, 16'h0000, 1'b0);
    expect_pulse(0, 0, base + 6, 16'hA007, 1'b1);
`endif
    host_we[0] = 1'b1; host_addr[0] = 16'h0006; host_wdata[0] = 16'hA007;
    cpu_addr[0] = 16'h0006;
    host_req[0] = 1'b1; cpu_req[0] = 1'b1;
    fork
      begin wait_pulse(0, 1, 40); host_req[0] = 1'b0; end
      begin wait_pulse(0, 0, 40); cpu_req[0] = 1'b0; end
    join

    // Ten back-to-back host writes with a CPU request held throughout.
    @(negedge clk);
    base = cyc;
`ifdef IMEM_ARB_RR_EN
    n_cpu_burst = 10;
    for (int j = 0; j < 10; j++) begin
      expect_pulse(0, 0, base + 3 + 7*j, 16'h0008, 1'b1);
      expect_pulse(0, 1, base + 6 + 7*j, 16'h0000, 1'b0);
    end
`else
    n_cpu_burst = 1;
    for (int j = 0; j < 10; j++) expect_pulse(0, 1, base + 2 + 3*j, 16'h0000, 1'b0);
    expect_pulse(0, 0, base + 33, 16'h0008, 1'b1);
`endif
    cpu_addr[0] = 16'h0000;
    cpu_req[0]  = 1'b1;
    host_we[0]  = 1'b1;
    host_req[0] = 1'b1;
    fork
      begin
        for (int j = 0; j < 10; j++) begin
          host_addr[0]  = 16'(16 + j);
          host_wdata[0] = 16'(16'h5000 + j);
          wait_pulse(0, 1, 100);
        end
        host_req[0] = 1'b0;
      end
      begin
        for (int j = 0; j < n_cpu_burst; j++) wait_pulse(0, 0, 100);
        cpu_req[0] = 1'b0;
      end
    join
    host_txn(0, 1'b0, 16'd25, 16'h0000, 3, 16'h5009);

    // Reset asserted during WAIT of a CPU fetch aborts it silently.
    @(negedge clk);
    cpu_addr[0] = 16'h0001;
    cpu_req[0]  = 1'b1;
    @(negedge clk);   // ACCESS
    @(negedge clk);   // WAIT
    rst = 1'b0;
    #1;
    check_zero(0, "reset_mid_wait");
    cpu_req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    vld_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_vld[0]) vld_seen++;
    end
    check_val("vld_after_reset", 16'(vld_seen), 16'h0000);
    cpu_txn(0, 16'h0001, 3, 16'h0402);

    // RD_LAT=4 instance: read acks after 6 cycles.
    host_txn(1, 1'b1, 16'h0003, 16'hBEEF, 2, 16'h0000);
    host_txn(1, 1'b0, 16'h0003, 16'h0000, 6, 16'hBEEF);
    cpu_txn(1, 16'h0003, 6, 16'hBEEF);

    repeat (4) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one single-port program RAM between the CPU instruction-fetch port and a host loader/debug port.
- CPU side uses the existing fetch handshake: addr/request out of the CPU, instruction plus one-cycle valid pulse back.
- Host side can write program words before or while the CPU runs, and can read them back.
- Sits between the cpu module and the program RAM; it sequences every RAM access through one FSM.

Parameters:
- AW, 16, address width of both ports and of the RAM.
- DW, 16, data/instruction width.
- RD_LAT, 1, RAM read latency in cycles (valid range 1..15): cycles from the ram_en edge until ram_rdata is valid.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  fetch request; this is the CPU's en_ram_in.
- cpu_addr  in  AW  fetch address.
- cpu_ins  out  DW  fetched instruction; held until the next fetch completes.
- cpu_vld  out  1  one-cycle pulse when cpu_ins is updated; this is the CPU's en_ram_out.
- host_req  in  1  host access request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_rdata  out  DW  host read data; held until the next host read completes.
- host_ack  out  1  one-cycle completion pulse.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM returns to IDLE and the latency counter clears.
  - All outputs go to 0, including cpu_ins, host_rdata and the ram_* outputs.
  - Reset mid-access aborts the access silently: no vld/ack is issued. Requesters must re-request after reset.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Samples cpu_req and host_req each cycle.
  - If either is high, registers the grant (owner, we, addr, wdata) and moves to ACCESS.
  - Owner, addr, we and wdata are frozen for the rest of the transaction; requester changes are ignored until the next IDLE.
- ACCESS (1 cycle):
  - ram_en=1; ram_addr = latched addr; ram_we = latched we (always 0 for the CPU); ram_wdata = latched wdata.
  - On a write, goes to RESP.
  - On a read, loads the counter with RD_LAT and goes to WAIT.
- WAIT:
  - ram_en=0; the counter decrements each cycle.
  - When the counter reaches 1, captures ram_rdata into the owner's data register (cpu_ins or host_rdata) on that edge and goes to RESP.
- RESP (1 cycle):
  - Pulses cpu_vld or host_ack for the owner only, then returns to IDLE.
- Latency, counted from the edge where IDLE samples the request to the vld/ack cycle:
  - Read: 2+RD_LAT cycles (3 at default).
  - Write: 2 cycles.
  - Maximum throughput: one access per 3+RD_LAT cycles (reads) or per 3 cycles (writes).
- Request rule: requests are level.
  - A requester must drop req in the cycle following its vld/ack.
  - A req still high when IDLE is re-entered is serviced as a new request. This is intentional; a back-to-back fetch of the same address is legal.
- Arbitration (default build): fixed priority, host over CPU, decided only in IDLE.
  - A pending CPU request waits, with cpu_vld=0, while the host holds the RAM.
  - CPU starvation under continuous host traffic is accepted in this build.
- Simultaneous events:
  - A request arriving during ACCESS/WAIT/RESP is not lost as long as it is held; it is arbitrated at the next IDLE.
  - cpu_vld and host_ack are never high in the same cycle.
  - ram_en is never high for two consecutive cycles.
- Host write to the address currently being fetched: serialized by the FSM. The fetch returns old or new data depending on grant order, never a mix.

Optional Feature:
- Macro: IMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_owner register, reset to CPU, records who last completed.
  - When both requests are high in IDLE, the grant goes to the port that did not own the last completed transaction.
  - A single requester is always granted immediately.
- Undefined: fixed host-over-CPU priority as above, and no last_owner register exists.

Test Plan:
- Host loads the RAM: write 0x0008 to addr 0 and 0x0402 to addr 1.
  - host_ack follows 2 cycles after each request is sampled.
  - ram_we=1 only in each ACCESS cycle.
  - Reading back addr 1 returns host_rdata=0x0402 with ack 3 cycles after the request.
- CPU fetch of addr 0 with RD_LAT=1 (RAM holds 0x0008 at addr 0):
  - cpu_vld pulses exactly once, 3 cycles after the request is sampled.
  - cpu_ins=0x0008 and holds after cpu_req drops.
- cpu_req and host_req rise in the same cycle (host write 0xA007 to addr 6, CPU fetching addr 6):
  - Default build: host_ack first, then cpu_vld with cpu_ins=0xA007.
  - IMEM_ARB_RR_EN build with last_owner=host: CPU first with the old data, then host_ack.
- Continuous host_req for 10 accesses while cpu_req is held high:
  - Default build: no cpu_vld until host_req drops.
  - Round-robin build: strictly alternating grants.
- rst pulled low during WAIT of a CPU fetch:
  - All outputs are 0 immediately (asynchronous).
  - After release, no cpu_vld appears until a new request.
- RD_LAT=4:
  - The read ack appears 6 cycles after the request is sampled.
  - ram_en is high for exactly one cycle per access.
